// File: rtl/risc_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and grant sources.
package risc_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_D
    } gnt_src_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational priority pick between fetch and data: data wins unless fetch
// has lost STARVE_LIMIT arbitrations in a row.
module mem_arb_prio
    import risc_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic [1:0]          gnt
);

    logic starved;

    assign starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        gnt = GNT_NONE;
        if (if_req && (!d_req || starved)) begin
            gnt = GNT_IF;
        end else if (d_req) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// data load/store, one transaction at a time, waiting out the memory latency.
module mem_port_arbiter
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int LAT_W    = $clog2(MEM_LATENCY + 1);

    arb_state_t          state;
    gnt_src_t            owner;
    gnt_src_t            gnt;
    logic                is_write;
    logic [LAT_W-1:0]    lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [1:0]          pick;

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .STARVE_W    (STARVE_W)
    ) u_prio (
        .if_req    (if_req),
        .d_req     (d_req),
        .starve_cnt(starve_cnt),
        .gnt       (pick)
    );

    // Grants are gated by reset so nothing is offered while reset is held.
    always_comb begin
        gnt = GNT_NONE;
        if (state == ARB_IDLE && !reset) begin
            gnt = gnt_src_t'(pick);
        end
    end

    assign if_ready = (gnt == GNT_IF);
    assign d_ready  = (gnt == GNT_D);

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt)
            GNT_IF: begin
                mem_read = 1'b1;
                mem_addr = if_addr;
            end
            GNT_D: begin
                mem_addr = d_addr;
                if (d_we) begin
                    mem_write = 1'b1;
                    mem_wdata = d_wdata;
                end else begin
                    mem_read = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= GNT_NONE;
            is_write   <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (gnt != GNT_NONE) begin
                        state    <= ARB_BUSY;
                        owner    <= gnt;
                        is_write <= (gnt == GNT_D) && d_we;
                        lat_cnt  <= LAT_W'(MEM_LATENCY);
                        if (gnt == GNT_IF) begin
                            starve_cnt <= '0;
                        end else if (if_req && starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                ARB_BUSY: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    // Memory data is valid during the cycle the counter reads 1.
                    if (lat_cnt == LAT_W'(1)) begin
                        state <= ARB_IDLE;
                        owner <= GNT_NONE;
                        if (owner == GNT_IF) begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end else begin
                            d_rvalid <= 1'b1;
                            if (!is_write) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
